join_stream_aligner: RTL

- Sequencer in front of join_complex in the two-input join NoC block.
- Sits between the two chdr_deframer outputs (I on port 0, Q on port 1) and the joiner/framer.
- Consumes I and Q samples in lock-step and keeps the two streams packet-aligned: a packet boundary on one side closes the output packet and drains the other side to its boundary.
- Reports misalignment and starvation through status outputs for readback.

---
 rtl/join_pkg.sv | 13 +
 rtl/join_out_reg.sv | 52 +++++
 rtl/join_stream_aligner.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/join_pkg.sv
// Shared definitions for the two-input join path: aligner FSM state
// encoding and the CHDR header sideband width.
package join_pkg;

    localparam int CHDR_TUSER_W = 128;

    typedef enum logic [1:0] {
        ST_PASS    = 2'd0,
        ST_DRAIN_I = 2'd1,
        ST_DRAIN_Q = 2'd2
    } join_state_t;

endpackage

// File: rtl/join_out_reg.sv
// One-entry AXI-stream output register. It reloads in the same cycle the held
// word is taken, so back-to-back transfers need no bubble.
module join_out_reg #(
    parameter int DATA_W = 32,
    parameter int USER_W = 128
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [USER_W-1:0] i_user,
    input  logic              i_last,
    output logic              o_can_load,
    output logic [DATA_W-1:0] o_tdata,
    output logic [USER_W-1:0] o_tuser,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              i_tready
);

    logic              r_vld;
    logic [DATA_W-1:0] r_data;
    logic [USER_W-1:0] r_user;
    logic              r_last;

    assign o_can_load = !r_vld || i_tready;
    assign o_tdata    = r_data;
    assign o_tuser    = r_user;
    assign o_tlast    = r_last;
    assign o_tvalid   = r_vld;

    // Payload only changes on load, which keeps it stable while stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_user <= '0;
            r_last <= 1'b0;
        end else if (i_clear) begin
            r_vld <= 1'b0;
        end else if (i_load) begin
            r_vld  <= 1'b1;
            r_data <= i_data;
            r_user <= i_user;
            r_last <= i_last;
        end else if (i_tready) begin
            r_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/join_stream_aligner.sv
// Lock-step I/Q sequencer ahead of the joiner: pairs samples, closes the output
// packet on the first tlast seen on either side and drains the other side to its end.
module join_stream_aligner
    import join_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TUSER_W = CHDR_TUSER_W,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     ii_tdata,
    input  logic [TUSER_W-1:0]   ii_tuser,
    input  logic                 ii_tlast,
    input  logic                 ii_tvalid,
    output logic                 ii_tready,
    input  logic [WIDTH-1:0]     iq_tdata,
    input  logic                 iq_tlast,
    input  logic                 iq_tvalid,
    output logic                 iq_tready,
    output logic [2*WIDTH-1:0]   o_tdata,
    output logic [TUSER_W-1:0]   o_tuser,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic [CNT_W-1:0]     misalign_cnt,
    output logic                 timeout_err,
    output logic [1:0]           state_dbg
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

    join_state_t      r_state;
    join_state_t      w_next;
    logic [CNT_W-1:0] r_mis;
    logic [TO_W-1:0]  r_starve;
    logic             r_to;
    logic             w_can_load;
    logic             w_go;
    logic             w_i_rdy;
    logic             w_q_rdy;
    logic             w_load;
    logic             w_mis_inc;
    logic             w_starving;

    assign w_go       = enable && !clear && w_can_load;
    assign w_starving = (r_state == ST_PASS) && enable && (ii_tvalid ^ iq_tvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_PASS;
        end else if (clear) begin
            r_state <= ST_PASS;
        end else begin
            r_state <= w_next;
        end
    end

    // In PASS both sides are taken together; a drain state only discards words
    // and so does not wait on the output stage.
    always_comb begin
        w_next    = r_state;
        w_i_rdy   = 1'b0;
        w_q_rdy   = 1'b0;
        w_load    = 1'b0;
        w_mis_inc = 1'b0;
        case (r_state)
            ST_PASS: begin
                w_i_rdy = w_go && ii_tvalid && iq_tvalid;
                w_q_rdy = w_i_rdy;
                w_load  = w_i_rdy;
                if (w_i_rdy && (ii_tlast != iq_tlast)) begin
                    w_mis_inc = 1'b1;
                    w_next    = ii_tlast ? ST_DRAIN_Q : ST_DRAIN_I;
                end
            end
            ST_DRAIN_Q: begin
                w_q_rdy = enable && !clear;
                if (w_q_rdy && iq_tvalid && iq_tlast) begin
                    w_next = ST_PASS;
                end
            end
            ST_DRAIN_I: begin
                w_i_rdy = enable && !clear;
                if (w_i_rdy && ii_tvalid && ii_tlast) begin
                    w_next = ST_PASS;
                end
            end
            default: w_next = ST_PASS;
        endcase
    end

    // Misalignment count saturates; the starvation flag is sticky until clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mis    <= '0;
            r_starve <= '0;
            r_to     <= 1'b0;
        end else if (clear) begin
            r_mis    <= '0;
            r_starve <= '0;
            r_to     <= 1'b0;
        end else begin
            if (w_mis_inc && (r_mis != {CNT_W{1'b1}})) begin
                r_mis <= r_mis + CNT_W'(1);
            end
            if (!w_starving) begin
                r_starve <= '0;
            end else if (r_starve == TO_MAX) begin
                r_to <= 1'b1;
            end else begin
                r_starve <= r_starve + TO_W'(1);
            end
        end
    end

    join_out_reg #(
        .DATA_W (2*WIDTH),
        .USER_W (TUSER_W)
    ) u_out (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clear    (clear),
        .i_load     (w_load),
        .i_data     ({ii_tdata, iq_tdata}),
        .i_user     (ii_tuser),
        .i_last     (ii_tlast || iq_tlast),
        .o_can_load (w_can_load),
        .o_tdata    (o_tdata),
        .o_tuser    (o_tuser),
        .o_tlast    (o_tlast),
        .o_tvalid   (o_tvalid),
        .i_tready   (o_tready)
    );

    assign ii_tready    = w_i_rdy;
    assign iq_tready    = w_q_rdy;
    assign misalign_cnt = r_mis;
    assign timeout_err  = r_to;
    assign state_dbg    = r_state;

endmodule
